// File: rtl/ex11_demux4_pkg.sv
// Shared constants for the ex11 1-to-4 word distributor.
package ex11_pkg;
    localparam int WIDTH_DEF = 4;
    localparam int NCH       = 4;
    localparam logic [1:0] CH0 = 2'd0;
    localparam logic [1:0] CH1 = 2'd1;
    localparam logic [1:0] CH2 = 2'd2;
    localparam logic [1:0] CH3 = 2'd3;
endpackage

// File: rtl/ex11_demux4_if.sv
// Input stream, per-channel output handshakes and status for ex11_demux4.
interface ex11_demux4_if
    import ex11_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_sel;
    logic             auto_mode;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic [WIDTH-1:0] out_data3;
    logic [NCH-1:0]   out_valid;
    logic [NCH-1:0]   out_ready;
    logic [1:0]       rr_ptr;
    logic [CNT_W-1:0] acc_cnt;

    modport master (
        output in_data, in_valid, in_sel, auto_mode, out_ready,
        input  in_ready, out_data0, out_data1, out_data2, out_data3,
               out_valid, rr_ptr, acc_cnt
    );

    modport slave (
        input  in_data, in_valid, in_sel, auto_mode, out_ready,
        output in_ready, out_data0, out_data1, out_data2, out_data3,
               out_valid, rr_ptr, acc_cnt
    );
endinterface

// File: rtl/ex11_demux4_chan_reg.sv
// One-entry channel holding register; data is kept after the sink drains it.
module ex11_chan_reg
    import ex11_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid
);
    // load wins over drain so a same-cycle refill leaves no bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= din;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/ex11_demux4.sv
// 1-to-4 demux: routes each accepted word to a channel register by in_sel or rotating pointer.
module ex11_demux4
    import ex11_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    ex11_demux4_if.slave   bus
);
    logic [NCH-1:0][WIDTH-1:0] data;
    logic [NCH-1:0]            valid;
    logic [1:0]                dest;
    logic                      accept;
    logic [1:0]                rr_ptr;
    logic [CNT_W-1:0]          acc_cnt;

    assign dest         = bus.auto_mode ? rr_ptr : bus.in_sel;
    assign bus.in_ready = ~valid[dest] | bus.out_ready[dest];
    assign accept       = bus.in_valid & bus.in_ready;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        ex11_chan_reg #(.WIDTH(WIDTH)) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (accept && (dest == 2'(k))),
            .din   (bus.in_data),
            .ready (bus.out_ready[k]),
            .data  (data[k]),
            .valid (valid[k])
        );
    end

    // pointer only moves on an auto-mode accept; strict rotation, no skipping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= CH0;
            acc_cnt <= '0;
        end else if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
            if (bus.auto_mode) rr_ptr <= rr_ptr + 2'd1;
        end
    end

    assign bus.out_data0 = data[CH0];
    assign bus.out_data1 = data[CH1];
    assign bus.out_data2 = data[CH2];
    assign bus.out_data3 = data[CH3];
    assign bus.out_valid = valid;
    assign bus.rr_ptr    = rr_ptr;
    assign bus.acc_cnt   = acc_cnt;
endmodule
